multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencing controller for the RV32I datapath. It replaces per-instruction combinational control with an FSM that steps through FETCH/DECODE/EXEC/MEM/WB phases. It handshakes with instruction and data memories, latches the instruction register, and emits register-file, memory, write-back-select and PC-update strobes. It also keeps a retired-instruction counter and halts on an illegal opcode.

Parameters:
CNT_W, 32, width of instret counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr  in  32  instruction word from imem, valid when imem_ready=1
imem_ready  in  1  imem read completes this cycle
dmem_ready  in  1  dmem access completes this cycle
br_taken  in  1  branch comparator result from datapath, valid in EXEC
imem_req  out  1  fetch request
ir_load  out  1  load instruction register
ir  out  32  latched instruction
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
rf_we  out  1  register-file write enable
wbsel  out  2  00 ALU, 01 DMEM, 10 PC+4
alu_src_imm  out  1  ALU operand B is immediate (0 only for opcode 0110011)
pc_we  out  1  PC update strobe
pc_sel  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 JALR target
retire  out  1  one-cycle pulse per completed instruction
instret  out  CNT_W  retired-instruction count
halted  out  1  illegal opcode seen, core stopped

Behaviour:
- Reset (rst=1 at edge): state<=FETCH, ir<=0, instret<=0. rst has priority over every other event, including mid-MEM or mid-fetch waits; the outstanding request is simply dropped.
- Output decode: strobes are decoded combinationally from the state, the ir opcode and the ready inputs. Every strobe not listed for a state is 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_load=1, ir<=instr, go to DECODE.
  - Otherwise stay (unbounded wait).
- DECODE:
  - Classify ir[6:0] among: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode goes to HALT; otherwise go to EXEC.
- EXEC: alu_src_imm valid from here on.
  - Branch: pc_we=1, pc_sel=br_taken?01:00, retire=1, go to FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM:
  - dmem_req=1, dmem_we=(store).
  - Waits on dmem_ready.
  - On ready, store: pc_we=1, pc_sel=00, retire=1, go to FETCH.
  - On ready, load: go to WB.
- WB:
  - rf_we=1.
  - wbsel: 01 for load, 10 for JAL/JALR, else 00.
  - pc_we=1; pc_sel: 01 for JAL, 10 for JALR, else 00.
  - retire=1, go to FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Only rst exits HALT.
  - The illegal instruction does not retire.
- Latency with zero-wait memories: branch 3 cycles; ALU/LUI/AUIPC/JAL/JALR/store 4; load 5. Each memory wait cycle adds 1.
- instret: increments on every retire pulse and wraps to 0 after all-ones with no flag.
- Data hold: ir holds its value outside ir_load. dmem_req and imem_req stay high until the corresponding ready arrives; ready seen in any other state is ignored.

Decomposition:
- Shared package:
  - opcode constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - wbsel encodings (WB_ALU, WB_DMEM, WB_PC4)
  - pc_sel encodings (PC_PLUS4, PC_TGT, PC_JALR)
- Sub-module ctrl_opdecode: combinational opcode-class decoder producing is_r, is_load, is_store, is_branch, is_jal, is_jalr, and illegal. The FSM remains in multicycle_ctrl.

Test Plan:
- Reset then add x1,x2,x3 (0x003100B3), zero-wait memories -> states FETCH,DECODE,EXEC,WB. rf_we=1 in cycle 4 with wbsel=00, alu_src_imm=0. retire at cycle 4; instret=1.
- lw (0x0000A083) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0. Then WB with wbsel=01, rf_we=1. Total 8 cycles.
- beq (0x00208463) with br_taken=1, then again with br_taken=0 -> each in 3 cycles, pc_sel=01 then 00, rf_we never asserted.
- jalr (0x000080E7) -> WB with wbsel=10, pc_sel=10, rf_we=1.
- Illegal opcode 0x0000007F -> halted=1 from the cycle after DECODE. No further imem_req and instret unchanged. rst returns to FETCH with halted=0.
- rst asserted during a MEM wait for sw -> next cycle FETCH with dmem_req=0 and instret=0. Also preload instret near 2^CNT_W-1 (CNT_W=4 build, 16 retires) -> wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// opcode constants, FSM state encoding, and the write-back / PC-select
// encodings that the datapath muxes expect.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_DMEM = 2'b01,
    WB_PC4  = 2'b10
  } wbsel_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_TGT   = 2'b01,
    PC_JALR  = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/multicycle_ctrl_opdecode.sv
// Combinational opcode-class decoder.
// Ports:
//   opcode_i    - ir[6:0]
//   is_*_o      - one-hot-ish class flags for the opcodes the FSM branches on
//   illegal_o   - opcode is not one of the nine supported RV32I major opcodes
module ctrl_opdecode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       is_r_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jal_o,
  output logic       is_jalr_o,
  output logic       illegal_o
);

  always_comb begin
    is_r_o      = 1'b0;
    is_load_o   = 1'b0;
    is_store_o  = 1'b0;
    is_branch_o = 1'b0;
    is_jal_o    = 1'b0;
    is_jalr_o   = 1'b0;
    illegal_o   = 1'b0;
    unique case (opcode_i)
      OP_R:                     is_r_o      = 1'b1;
      OP_LOAD:                  is_load_o   = 1'b1;
      OP_STORE:                 is_store_o  = 1'b1;
      OP_BRANCH:                is_branch_o = 1'b1;
      OP_JAL:                   is_jal_o    = 1'b1;
      OP_JALR:                  is_jalr_o   = 1'b1;
      OP_IMM, OP_LUI, OP_AUIPC: ;
      default:                  illegal_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for an RV32I datapath.
// Steps FETCH -> DECODE -> EXEC -> [MEM] -> [WB], handshaking with the
// instruction and data memories, and halts permanently (until reset) on an
// unsupported opcode.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   instr, imem_ready     - fetched word and its completion strobe
//   dmem_ready            - data access completion strobe
//   br_taken              - branch comparator result (used in EXEC)
//   imem_req, ir_load, ir - fetch request, IR load strobe, latched instruction
//   dmem_req, dmem_we     - data request / write
//   rf_we, wbsel          - register write enable and write-back source
//   alu_src_imm           - ALU operand B is the immediate
//   pc_we, pc_sel         - PC update strobe and source
//   retire, instret       - retire pulse and wrapping retired count
//   halted                - illegal opcode seen
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic [31:0]      ir,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic [1:0]       wbsel,
  output logic             alu_src_imm,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);

  state_e             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   instret_q;

  logic is_r, is_load, is_store, is_branch, is_jal, is_jalr, illegal;

  ctrl_opdecode u_opdecode (
    .opcode_i    (ir_q[6:0]),
    .is_r_o      (is_r),
    .is_load_o   (is_load),
    .is_store_o  (is_store),
    .is_branch_o (is_branch),
    .is_jal_o    (is_jal),
    .is_jalr_o   (is_jalr),
    .illegal_o   (illegal)
  );

  // Strobes are a function of current state, latched opcode and the ready
  // inputs; ready inputs only matter in the state that issued the request.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wbsel       = WB_ALU;
    alu_src_imm = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_PLUS4;
    retire      = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = illegal ? HALT : EXEC;
      end
      EXEC: begin
        alu_src_imm = ~is_r;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? PC_TGT : PC_PLUS4;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        alu_src_imm = ~is_r;
        dmem_req    = 1'b1;
        dmem_we     = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        alu_src_imm = ~is_r;
        rf_we       = 1'b1;
        if (is_load)               wbsel = WB_DMEM;
        else if (is_jal || is_jalr) wbsel = WB_PC4;
        pc_we = 1'b1;
        if (is_jal)       pc_sel = PC_TGT;
        else if (is_jalr) pc_sel = PC_JALR;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign ir      = ir_q;
  assign instret = instret_q;
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          imem_ready, dmem_ready, br_taken;
  logic          imem_req, ir_load, dmem_req, dmem_we, rf_we, alu_src_imm;
  logic          pc_we, retire, halted;
  logic [1:0]    wbsel, pc_sel;
  logic [31:0]   ir;
  logic [CW-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
    .ir_load(ir_load), .ir(ir), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .wbsel(wbsel), .alu_src_imm(alu_src_imm), .pc_we(pc_we),
    .pc_sel(pc_sel), .retire(retire), .instret(instret), .halted(halted)
  );

  typedef struct packed {
    logic       imem_req, ir_load, dmem_req, dmem_we, rf_we;
    logic [1:0] wbsel;
    logic       alu_src_imm, pc_we;
    logic [1:0] pc_sel;
    logic       retire, halted;
  } strobes_t;

  strobes_t      obs;
  strobes_t      exp_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [31:0]   m_ir;
  logic [CW-1:0] m_instret;

  always_comb obs = {imem_req, ir_load, dmem_req, dmem_we, rf_we, wbsel,
                     alu_src_imm, pc_we, pc_sel, retire, halted};

  // One clock cycle: inputs driven at negedge, outputs checked #1 later,
  // reference IR / instret advanced after the rising edge.
  task automatic step(input logic r, input logic [31:0] ins, input logic ird,
                      input logic drd, input logic bt, input strobes_t e,
                      input string tag);
    strobes_t x;
    rst = r; instr = ins; imem_ready = ird; dmem_ready = drd; br_taken = bt;
    exp_q.push_back(e);
    #1;
    x = exp_q.pop_front();
    tests++;
    assert (obs === x) else begin
      fails++;
      $error("FAIL %s strobes got %b expected %b", tag, obs, x);
    end
    tests++;
    assert (ir === m_ir) else begin
      fails++;
      $error("FAIL %s ir got %h expected %h", tag, ir, m_ir);
    end
    tests++;
    assert (instret === m_instret) else begin
      fails++;
      $error("FAIL %s instret got %0d expected %0d", tag, instret, m_instret);
    end
    @(posedge clk);
    if (r) begin
      m_ir = '0;
      m_instret = '0;
    end else begin
      if (e.ir_load) m_ir = ins;
      if (e.retire)  m_instret = m_instret + 1'b1;
    end
    @(negedge clk);
  endtask

  // Builds the expected per-cycle strobe sequence for one instruction from
  // its opcode and drives it. Ready/br inputs are held high when they should
  // be ignored. rst_at >= 0 asserts rst on that MEM wait cycle.
  task automatic run_instr(input logic [31:0] ins, input int iwait,
                           input int dwait, input logic bt, input int rst_at);
    logic [6:0] op;
    logic r, ld, st, bq, jl, jr, legal;
    strobes_t e;
    op = ins[6:0];
    r  = (op == 7'b0110011);
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    bq = (op == 7'b1100011);
    jl = (op == 7'b1101111);
    jr = (op == 7'b1100111);
    legal = r | ld | st | bq | jl | jr | (op == 7'b0010011) |
            (op == 7'b0110111) | (op == 7'b0010111);
    for (int i = 0; i < iwait; i++) begin
      e = '0; e.imem_req = 1'b1;
      step(1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, e, "fetch_wait");
    end
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
    step(1'b0, ins, 1'b1, 1'b1, 1'b1, e, "fetch");
    e = '0;
    step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, e, "decode");
    if (!legal) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.halted = 1'b1;
        step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, e, "halt");
      end
      return;
    end
    e = '0; e.alu_src_imm = !r;
    if (bq) begin
      e.pc_we = 1'b1; e.pc_sel = bt ? 2'b01 : 2'b00; e.retire = 1'b1;
    end
    step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, bt, e, bq ? "branch_exec" : "exec");
    if (bq) return;
    if (ld || st) begin
      for (int i = 0; i < dwait; i++) begin
        e = '0; e.dmem_req = 1'b1; e.dmem_we = st; e.alu_src_imm = 1'b1;
        if (i == rst_at) begin
          step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, e, "mem_rst");
          return;
        end
        step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, e, "mem_wait");
      end
      e = '0; e.dmem_req = 1'b1; e.dmem_we = st; e.alu_src_imm = 1'b1;
      if (st) begin e.pc_we = 1'b1; e.retire = 1'b1; end
      step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, e, "mem_done");
      if (st) return;
    end
    e = '0; e.rf_we = 1'b1; e.alu_src_imm = !r; e.pc_we = 1'b1; e.retire = 1'b1;
    e.wbsel  = ld ? 2'b01 : ((jl || jr) ? 2'b10 : 2'b00);
    e.pc_sel = jl ? 2'b01 : (jr ? 2'b10 : 2'b00);
    step(1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, e, "wb");
  endtask

  initial begin
    strobes_t e;
    rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
    m_ir = '0; m_instret = '0;
    @(posedge clk);
    @(negedge clk);

    run_instr(32'h003100B3, 0, 0, 1'b0, -1); // add
    run_instr(32'h0000A083, 0, 3, 1'b0, -1); // lw, 3 wait cycles
    run_instr(32'h00208463, 0, 0, 1'b1, -1); // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, -1); // beq not taken
    run_instr(32'h000080E7, 0, 0, 1'b0, -1); // jalr
    run_instr(32'h00100093, 2, 0, 1'b0, -1); // addi, 2 fetch waits
    run_instr(32'h000010B7, 0, 0, 1'b0, -1); // lui
    run_instr(32'h004000EF, 0, 0, 1'b0, -1); // jal
    run_instr(32'h0020A023, 0, 1, 1'b0, -1); // sw, 1 wait
    for (int i = 0; i < 10; i++)             // instret 9 -> 19 mod 16 = 3
      run_instr(32'h00100093, 0, 0, 1'b0, -1);

    run_instr(32'h0000007F, 0, 0, 1'b0, -1); // illegal -> halt
    e = '0; e.halted = 1'b1;
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, e, "halt_rst");

    run_instr(32'h00100093, 0, 0, 1'b0, -1);
    run_instr(32'h00100093, 0, 0, 1'b0, -1);
    run_instr(32'h0020A023, 0, 4, 1'b0, 2);  // sw, reset mid-wait
    run_instr(32'h003100B3, 0, 0, 1'b0, -1); // fresh fetch after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
